proc_out_stream_buffer: RTL and testbench
=========================================

// Module: proc_out_stream_buffer
// PURPOSE
//  Sits directly downstream of the pixel processor (threshold/brightness stage). Buffers its
//  output words (no backpressure upstream) in a FIFO, re-issues them on a valid/ready stream
//  towards the output file writer, marks the final word of the frame with out_last, counts
//  the words in the frame and flags words lost to overflow.
// PARAMETERS
//  DATA_WIDTH  32  word width; matches the processor's data_out (32 or 64)
//  FIFO_DEPTH  8   buffer entries; power of 2, >=4
//  CNT_WIDTH   16  width of word_count
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           reset: asynchronous, active-low
//  in_data      in   DATA_WIDTH  processed word (processor data_out)
//  in_vld       in   1           in_data valid this cycle (processor data_out_vld)
//  in_done      in   1           one-cycle pulse, frame finished (processor done); may coincide with in_vld
//  out_data     out  DATA_WIDTH  head-of-FIFO word
//  out_vld      out  1           out_data valid
//  out_ready    in   1           consumer accepts when out_vld && out_ready
//  out_last     out  1           out_data is the final word of the frame
//  word_count   out  CNT_WIDTH   words written into the FIFO this frame; saturates at all-ones
//  overflow     out  1           sticky: at least one word dropped this frame
//  frame_done   out  1           one-cycle pulse after the last word is accepted downstream
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  Reset: out_vld=0, out_last=0, out_data=0, word_count=0, overflow=0, frame_done=0, busy=0.
//    FIFO pointers/count=0, state=IDLE. Reset mid-frame discards all buffered data immediately.
//  FSM: IDLE -> STREAM on first in_vld (word written, word_count:=1, overflow:=0).
//    IDLE -> FINISH on in_done without in_vld (empty frame, no words emitted).
//    STREAM -> DRAIN on in_done (the word in the same cycle, if any, is written first).
//    DRAIN -> FINISH when the last word is accepted (out_vld && out_ready && count==1).
//    FINISH -> IDLE after exactly 1 cycle; frame_done=1 only in FINISH.
//  Write: in_vld in IDLE/STREAM writes mem[wr_ptr] unless full; if full, word dropped, overflow:=1.
//    in_vld in DRAIN/FINISH: dropped, overflow:=1 (next frame must start after frame_done).
//  Read: show-ahead; out_data=mem[rd_ptr], out_vld=!empty in STREAM/DRAIN. Latency: word written
//    at edge N is visible on out_data after edge N (1 cycle). out_data/out_vld/out_last stable
//    while out_vld && !out_ready. Pop on out_vld && out_ready.
//  Simultaneous push and pop with FIFO full: pop frees space first; push succeeds, count unchanged.
//  out_last = (state==DRAIN) && (count==1). Never asserted in STREAM.
//  Pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits.
//  word_count increments per successful write only; holds through IDLE until next frame start.
//  overflow holds until next IDLE->STREAM transition.
// CONFIGURATION
//  OUT_STAT_EN defined: extra output ones_count [CNT_WIDTH+$clog2(DATA_WIDTH)-1:0], cleared at frame
//    start, adds popcount(in_data) per successful write; at frame_done,
//    ones_count/`PIXEL_SIZE = number of white (all-ones) pixels after thresholding.
//  OUT_STAT_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  proc_pkg (shared): `COLOR_SIZE (8), `PIXEL_SIZE (24), typedef enum {IDLE,STREAM,DRAIN,FINISH} out_state_t.
//  Sub-module: proc_sync_fifo (DATA_WIDTH, FIFO_DEPTH): mem, pointers, count, full/empty,
//    show-ahead read; FSM, counters and out_last stay in proc_out_stream_buffer.
// TESTING
//  1 Frame of 6 words 0x11..0x66, out_ready=1, in_done with 6th word -> out 0x11..0x66 in order,
//    out_last only on 0x66, word_count=6, frame_done 1 cycle after 0x66 accepted, overflow=0.
//  2 Same frame, out_ready=0 until in_done, then 1 (FIFO_DEPTH=8) -> all 6 words, no drop, out_data
//    stable while stalled.
//  3 10 words with out_ready=0 (FIFO_DEPTH=8) -> words 9,10 dropped, overflow=1, word_count=8,
//    out_last on word 8.
//  4 in_done with no prior in_vld -> out_vld never 1, frame_done pulses 1 cycle later, busy 1 cycle.
//  5 rst_n low mid-DRAIN with 3 words buffered -> all outputs 0 immediately (async), next frame clean.
//  6 OUT_STAT_EN, words 0xFFFFFFFF,0xFFFFFFFF,0xFFFF0000 -> ones_count=80 at frame_done.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the pixel-processor output path.
// Provides `COLOR_SIZE / `PIXEL_SIZE macros and the output-buffer FSM state type.
`ifndef PROC_PKG_SV
`define PROC_PKG_SV

`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

package proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } out_state_t;

endpackage

`endif

// File: rtl/proc_sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, rst_n     clock, async active-low reset (pointers/count only)
//   push_i         write wr_data_i this cycle (caller guarantees space or a same-cycle pop)
//   pop_i          discard head this cycle (caller guarantees not empty)
//   wr_data_i      write data
//   rd_data_o      head-of-FIFO word (show-ahead)
//   full_o         count == FIFO_DEPTH
//   count_next_o   occupancy after the current edge
module proc_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             full_o,
    output logic [$clog2(FIFO_DEPTH):0]      count_next_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_comb begin
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    assign rd_data_o    = mem_q[rd_ptr_q];
    assign full_o       = (count_q == CW'(FIFO_DEPTH));
    assign count_next_o = count_d;

endmodule

// File: rtl/proc_out_stream_buffer.sv
// Output stream buffer behind the pixel processor: buffers words (no upstream
// backpressure), re-issues them on valid/ready, tags the last word of the frame,
// counts words written and flags drops.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_data/in_vld    processed word and its valid
//   in_done           one-cycle end-of-frame pulse (may coincide with in_vld)
//   out_data/out_vld  head-of-FIFO word and valid; out_ready accepts
//   out_last          out_data is the final word of the frame
//   word_count        words written this frame (saturating)
//   overflow          sticky drop flag for the frame
//   frame_done        one-cycle pulse after the last word is accepted
//   busy              FSM not idle
//   ones_count        (only with OUT_STAT_EN) popcount sum of written words
// Build option: define OUT_STAT_EN to add the ones_count statistic.
module proc_out_stream_buffer
    import proc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_vld,
    input  logic                  in_done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vld,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  overflow,
    output logic                  frame_done,
    output logic                  busy
`ifdef OUT_STAT_EN
    ,
    output logic [CNT_WIDTH+$clog2(DATA_WIDTH)-1:0] ones_count
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    out_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  overflow_q, overflow_d;
    logic                  out_vld_q, out_vld_d;
    logic                  out_last_q, out_last_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;

    logic                  push, pop, drop, wr_open, frame_start, full;
    logic [CW-1:0]         fifo_count_d;
    logic [DATA_WIDTH-1:0] head;

    assign wr_open     = (state_q == IDLE) || (state_q == STREAM);
    assign pop         = out_vld_q && out_ready;
    // A same-cycle pop frees a slot, so a full FIFO still accepts a push.
    assign push        = in_vld && wr_open && (!full || pop);
    assign drop        = in_vld && !push;
    assign frame_start = (state_q == IDLE) && in_vld;

    proc_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .pop_i        (pop),
        .wr_data_i    (in_data),
        .rd_data_o    (head),
        .full_o       (full),
        .count_next_o (fifo_count_d)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, counters and look-ahead output flags.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_vld)       state_d = in_done ? DRAIN : STREAM;
                else if (in_done) state_d = FINISH;
            end
            STREAM: begin
                // Nothing left to drain: skip straight to FINISH.
                if (in_done) state_d = (fifo_count_d == '0) ? FINISH : DRAIN;
            end
            DRAIN: begin
                if (fifo_count_d == '0) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_start) begin
            word_count_d = CNT_WIDTH'(1);
            overflow_d   = 1'b0;
        end else begin
            if (push && (word_count_q != '1)) word_count_d = word_count_q + CNT_WIDTH'(1);
            if (drop) overflow_d = 1'b1;
        end

        // Outputs registered from next state so they line up with the FIFO contents.
        out_vld_d    = ((state_d == STREAM) || (state_d == DRAIN)) && (fifo_count_d != '0);
        out_last_d   = (state_d == DRAIN) && (fifo_count_d == CW'(1));
        frame_done_d = (state_d == FINISH);
        busy_d       = (state_d != IDLE);
    end

    // Head word is forced to zero whenever nothing valid is presented.
    assign out_data   = out_vld_q ? head : '0;
    assign out_vld    = out_vld_q;
    assign out_last   = out_last_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

`ifdef OUT_STAT_EN
    localparam int unsigned PW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned OW = CNT_WIDTH + $clog2(DATA_WIDTH);

    logic [PW-1:0] bit_sum;
    logic [OW-1:0] ones_q, ones_d;

    // Popcount of the incoming word, accumulated per successful write.
    always_comb begin
        bit_sum = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) bit_sum = bit_sum + PW'(in_data[i]);
        ones_d = ones_q;
        if (frame_start)  ones_d = OW'(bit_sum);
        else if (push)    ones_d = ones_q + OW'(bit_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ones_q <= '0;
        else        ones_q <= ones_d;
    end

    assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_proc_out_stream_buffer.sv
// Directed bench for proc_out_stream_buffer (DATA_WIDTH=32, FIFO_DEPTH=8, CNT_WIDTH=16).
module tb_proc_out_stream_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_vld, in_done;
    logic [31:0] out_data;
    logic        out_vld, out_ready, out_last;
    logic [15:0] word_count;
    logic        overflow, frame_done, busy;
`ifdef OUT_STAT_EN
    logic [20:0] ones_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    proc_out_stream_buffer #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .in_done    (in_done),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .word_count (word_count),
        .overflow   (overflow),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef OUT_STAT_EN
        ,
        .ones_count (ones_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic dn);
        in_vld  = v;
        in_data = d;
        in_done = dn;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #12;
        chk("rst_out_vld",    64'(out_vld),    64'(0));
        chk("rst_out_last",   64'(out_last),   64'(0));
        chk("rst_out_data",   64'(out_data),   64'(0));
        chk("rst_word_count", 64'(word_count), 64'(0));
        chk("rst_overflow",   64'(overflow),   64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_busy",       64'(busy),       64'(0));
        @(negedge clk); rst_n = 1'b1;
        tick();

        // 1: six words with out_ready high; each word appears the cycle after it is written.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'((i + 1) * 32'h11), 1'(i == 5));
            tick();
            chk("t1_vld",  64'(out_vld),  64'(1));
            chk("t1_data", 64'(out_data), 64'((i + 1) * 32'h11));
            chk("t1_last", 64'(out_last), 64'(i == 5));
        end
        chk("t1_wcount", 64'(word_count), 64'(6));
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("t1_frame_done", 64'(frame_done), 64'(1));
        chk("t1_vld_off",    64'(out_vld),    64'(0));
        chk("t1_busy",       64'(busy),       64'(1));
        chk("t1_overflow",   64'(overflow),   64'(0));
        tick();
        chk("t1_fd_pulse", 64'(frame_done), 64'(0));
        chk("t1_idle",     64'(busy),       64'(0));
        chk("t1_wc_hold",  64'(word_count), 64'(6));

        // 2: stalled until in_done; head stays 0x11.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'((i + 1) * 32'h11), 1'(i == 5));
            tick();
            chk("t2_stall_data", 64'(out_data), 64'(32'h11));
            chk("t2_stall_last", 64'(out_last), 64'(0));
        end
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("t2_stall_hold", 64'(out_data), 64'(32'h11));
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk("t2_vld",  64'(out_vld),  64'(1));
            chk("t2_data", 64'(out_data), 64'(k * 32'h11));
            chk("t2_last", 64'(out_last), 64'(k == 6));
            tick();
        end
        chk("t2_frame_done", 64'(frame_done), 64'(1));
        chk("t2_overflow",   64'(overflow),   64'(0));
        chk("t2_wcount",     64'(word_count), 64'(6));
        tick();

        // 3: ten words into an 8-deep FIFO with no reader; words 9 and 10 drop.
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'(i == 10));
            tick();
            if (i == 8) chk("t3_no_ovf_yet", 64'(overflow), 64'(0));
            if (i == 9) chk("t3_ovf",        64'(overflow), 64'(1));
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("t3_wcount", 64'(word_count), 64'(8));
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("t3_data", 64'(out_data), 64'(32'hA0 + 32'(k)));
            chk("t3_last", 64'(out_last), 64'(k == 8));
            tick();
        end
        chk("t3_frame_done", 64'(frame_done), 64'(1));
        chk("t3_ovf_sticky", 64'(overflow),   64'(1));
        tick();

        // 3b: full FIFO with simultaneous pop and push keeps the word.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'hB0 + 32'(i), 1'b0);
            tick();
        end
        chk("t3b_ovf_cleared", 64'(overflow), 64'(0));
        out_ready = 1'b1;
        drive(1'b1, 32'hB9, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("t3b_overflow", 64'(overflow),   64'(0));
        chk("t3b_wcount",   64'(word_count), 64'(9));
        out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("t3b_data", 64'(out_data), 64'(32'hB0 + 32'(k)));
            chk("t3b_last", 64'(out_last), 64'(k == 9));
            tick();
        end
        chk("t3b_frame_done", 64'(frame_done), 64'(1));
        tick();

        // 4: empty frame.
        drive(1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("t4_vld",        64'(out_vld),    64'(0));
        chk("t4_frame_done", 64'(frame_done), 64'(1));
        chk("t4_busy",       64'(busy),       64'(1));
        tick();
        chk("t4_fd_pulse", 64'(frame_done), 64'(0));
        chk("t4_busy_off", 64'(busy),       64'(0));
        chk("t4_vld_off",  64'(out_vld),    64'(0));

        // 5: asynchronous reset in DRAIN with three words buffered.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 1'(i == 3));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("t5_pre_vld", 64'(out_vld), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld",    64'(out_vld),    64'(0));
        chk("t5_rst_last",   64'(out_last),   64'(0));
        chk("t5_rst_data",   64'(out_data),   64'(0));
        chk("t5_rst_wcount", 64'(word_count), 64'(0));
        chk("t5_rst_busy",   64'(busy),       64'(0));
        chk("t5_rst_fd",     64'(frame_done), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hD1, 1'b0);
        tick();
        chk("t5_new_data", 64'(out_data), 64'(32'hD1));
        chk("t5_new_last", 64'(out_last), 64'(0));
        drive(1'b1, 32'hD2, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        chk("t5_new_data2", 64'(out_data),   64'(32'hD2));
        chk("t5_new_last2", 64'(out_last),   64'(1));
        chk("t5_wcount",    64'(word_count), 64'(2));
        tick();
        chk("t5_frame_done", 64'(frame_done), 64'(1));
        tick();

`ifdef OUT_STAT_EN
        // 6: popcount statistic, 32 + 32 + 16 = 80.
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 1'b0); tick();
        drive(1'b1, 32'hFFFF_FFFF, 1'b0); tick();
        drive(1'b1, 32'hFFFF_0000, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("t6_frame_done", 64'(frame_done), 64'(1));
        chk("t6_ones",       64'(ones_count), 64'(80));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
